// File: rtl/alu_writeback_stage_pkg.sv
// Shared constants for the ALU writeback stage: flag bit positions and
// branch/jump condition codes.
package alu_writeback_stage_pkg;

    localparam int FLAG_W = 5;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_HI = 4'b0100,
        COND_LS = 4'b0101,
        COND_GT = 4'b0110,
        COND_LE = 4'b0111,
        COND_FS = 4'b1000,
        COND_FC = 4'b1001,
        COND_LO = 4'b1010,
        COND_HS = 4'b1011,
        COND_LT = 4'b1100,
        COND_GE = 4'b1101,
        COND_UC = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/alu_writeback_stage_fifo.sv
// Small synchronous FIFO holding pending register-file writes.
module result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only occupancy state is cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU result sink: buffers register writes, drains them to the register file,
// keeps the committed PSR and evaluates branch conditions against it.
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int FLAG_W  = alu_writeback_stage_pkg::FLAG_W,
    parameter int RADDR_W = 4,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [FLAG_W-1:0]  in_flags,
    input  logic [RADDR_W-1:0] in_rdest,
    input  logic               in_wr_en,
    input  logic               in_flag_we,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [RADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    input  logic               psr_we,
    input  logic [FLAG_W-1:0]  psr_wdata,
    output logic [FLAG_W-1:0]  psr,
    input  logic [3:0]         cond,
    output logic               cond_true,
    output logic               busy
);

    localparam int ENTRY_W = RADDR_W + DATA_W;

    logic               accept;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign wb_valid = !fifo_empty;
    assign busy     = !fifo_empty;

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept && in_wr_en),
        .wdata ({in_rdest, in_data}),
        .pop   (wb_valid && wb_ready),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Gate the head so the write port reads zero whenever nothing is pending,
    // which keeps reset-time outputs clean without resetting FIFO storage.
    assign wb_addr = fifo_empty ? '0 : head[ENTRY_W-1:DATA_W];
    assign wb_data = fifo_empty ? '0 : head[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            psr <= '0;
        end else if (psr_we) begin
            psr <= psr_wdata;
        end else if (accept && in_flag_we) begin
            psr <= in_flags;
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_true =  psr[FLAG_Z];
            COND_NE: cond_true = !psr[FLAG_Z];
            COND_CS: cond_true =  psr[FLAG_C];
            COND_CC: cond_true = !psr[FLAG_C];
            COND_HI: cond_true =  psr[FLAG_L];
            COND_LS: cond_true = !psr[FLAG_L];
            COND_GT: cond_true =  psr[FLAG_N];
            COND_LE: cond_true = !psr[FLAG_N];
            COND_FS: cond_true =  psr[FLAG_F];
            COND_FC: cond_true = !psr[FLAG_F];
            COND_LO: cond_true = !psr[FLAG_L] && !psr[FLAG_Z];
            COND_HS: cond_true =  psr[FLAG_L] ||  psr[FLAG_Z];
            COND_LT: cond_true = !psr[FLAG_N] && !psr[FLAG_Z];
            COND_GE: cond_true =  psr[FLAG_N] ||  psr[FLAG_Z];
            COND_UC: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: condition table, directed
// handshake sequences and a randomized run against a queue-based model.
module tb_alu_writeback_stage;

    localparam int DATA_W  = 16;
    localparam int FLAG_W  = 5;
    localparam int RADDR_W = 4;
    localparam int DEPTH   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [FLAG_W-1:0]  in_flags;
    logic [RADDR_W-1:0] in_rdest;
    logic               in_wr_en;
    logic               in_flag_we;
    logic               wb_valid;
    logic               wb_ready;
    logic [RADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               psr_we;
    logic [FLAG_W-1:0]  psr_wdata;
    logic [FLAG_W-1:0]  psr;
    logic [3:0]         cond;
    logic               cond_true;
    logic               busy;

    int total  = 0;
    int passed = 0;

    alu_writeback_stage #(
        .DATA_W  (DATA_W),
        .FLAG_W  (FLAG_W),
        .RADDR_W (RADDR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_flags   (in_flags),
        .in_rdest   (in_rdest),
        .in_wr_en   (in_wr_en),
        .in_flag_we (in_flag_we),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .psr_we     (psr_we),
        .psr_wdata  (psr_wdata),
        .psr        (psr),
        .cond       (cond),
        .cond_true  (cond_true),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] p;
        logic [3:0] c;
        logic       exp;
    } cond_vec_t;

    typedef struct {
        logic [RADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
    } wr_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_data    = '0;
        in_flags   = '0;
        in_rdest   = '0;
        in_wr_en   = 1'b0;
        in_flag_we = 1'b0;
        psr_we     = 1'b0;
        psr_wdata  = '0;
    endtask

    task automatic offer(input logic [3:0] rd, input logic [15:0] d, input logic we,
                         input logic fwe, input logic [4:0] fl);
        in_valid   = 1'b1;
        in_rdest   = rd;
        in_data    = d;
        in_wr_en   = we;
        in_flag_we = fwe;
        in_flags   = fl;
    endtask

    task automatic check_cond(input string name, input logic [3:0] c, input logic exp);
        cond = c;
        #1;
        check(name, 32'(cond_true), 32'(exp));
    endtask

    // Reference rule set: each code tests a named flag relation on the PSR.
    function automatic logic ref_cond(input logic [4:0] p, input logic [3:0] c);
        logic cf, lf, ff, zf, nf;
        logic base;
        cf = p[0]; lf = p[1]; ff = p[2]; zf = p[3]; nf = p[4];
        case (c[3:1])
            3'd0: base = zf;
            3'd1: base = cf;
            3'd2: base = lf;
            3'd3: base = nf;
            3'd4: base = ff;
            3'd5: base = !(lf || zf);
            3'd6: base = !(nf || zf);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd5 || c[3:1] == 3'd6) return c[0] ? !base : base;
        if (c == 4'd14) return 1'b1;
        if (c == 4'd15) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    cond_vec_t vecs [25];
    wr_t       q [$];
    logic [4:0] mpsr;

    initial begin
        vecs = '{
            '{5'b00000, 4'd0,  1'b0}, '{5'b00000, 4'd1,  1'b1}, '{5'b00000, 4'd14, 1'b1},
            '{5'b00000, 4'd15, 1'b0}, '{5'b00000, 4'd10, 1'b1}, '{5'b00000, 4'd12, 1'b1},
            '{5'b00000, 4'd11, 1'b0}, '{5'b00000, 4'd13, 1'b0},
            '{5'b01000, 4'd0,  1'b1}, '{5'b01000, 4'd10, 1'b0}, '{5'b01000, 4'd11, 1'b1},
            '{5'b00001, 4'd2,  1'b1}, '{5'b00001, 4'd3,  1'b0},
            '{5'b00010, 4'd4,  1'b1}, '{5'b00010, 4'd5,  1'b0}, '{5'b00010, 4'd10, 1'b0},
            '{5'b00010, 4'd11, 1'b1},
            '{5'b00100, 4'd8,  1'b1}, '{5'b00100, 4'd9,  1'b0},
            '{5'b10000, 4'd6,  1'b1}, '{5'b10000, 4'd7,  1'b0}, '{5'b10000, 4'd12, 1'b0},
            '{5'b10000, 4'd13, 1'b1},
            '{5'b11111, 4'd15, 1'b0}, '{5'b11111, 4'd14, 1'b1}
        };

        idle_inputs();
        wb_ready = 1'b0;
        cond     = 4'd0;
        reset    = 1'b1;

        // Reset then idle
        step();
        step();
        reset = 1'b0;
        check("rst_psr", 32'(psr), 32'h0);
        check("rst_wb_valid", 32'(wb_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wb_addr", 32'(wb_addr), 32'h0);
        check("rst_wb_data", 32'(wb_data), 32'h0);
        check_cond("rst_cond_uc", 4'd14, 1'b1);
        check_cond("rst_cond_eq", 4'd0, 1'b0);

        // Single write
        wb_ready = 1'b1;
        offer(4'd3, 16'h0016, 1'b1, 1'b1, 5'b00000);
        step();
        idle_inputs();
        check("single_valid", 32'(wb_valid), 32'h1);
        check("single_addr", 32'(wb_addr), 32'h3);
        check("single_data", 32'(wb_data), 32'h0016);
        step();
        check("single_drained", 32'(wb_valid), 32'h0);
        check("single_psr", 32'(psr), 32'h0);

        // Backpressure fill
        wb_ready = 1'b0;
        offer(4'd1, 16'h1111, 1'b1, 1'b0, 5'b0);
        step();
        check("bp_ready_after_one", 32'(in_ready), 32'h1);
        offer(4'd2, 16'h2222, 1'b1, 1'b0, 5'b0);
        step();
        check("bp_full_ready", 32'(in_ready), 32'h0);
        offer(4'd3, 16'h3333, 1'b1, 1'b0, 5'b0);
        step();
        idle_inputs();
        check("bp_still_full", 32'(in_ready), 32'h0);
        check("bp_head_addr", 32'(wb_addr), 32'h1);
        check("bp_head_data", 32'(wb_data), 32'h1111);
        wb_ready = 1'b1;
        step();
        check("bp_second_valid", 32'(wb_valid), 32'h1);
        check("bp_second_addr", 32'(wb_addr), 32'h2);
        check("bp_second_data", 32'(wb_data), 32'h2222);
        check("bp_ready_back", 32'(in_ready), 32'h1);
        step();
        check("bp_third_dropped", 32'(wb_valid), 32'h0);

        // Compare-only op
        offer(4'd5, 16'hBEEF, 1'b0, 1'b1, 5'b01000);
        #1;
        check("cmp_no_comb_bypass", 32'(psr), 32'h0);
        step();
        idle_inputs();
        check("cmp_no_write", 32'(wb_valid), 32'h0);
        check("cmp_psr", 32'(psr), 32'h08);
        check_cond("cmp_eq", 4'd0, 1'b1);
        check_cond("cmp_ne", 4'd1, 1'b0);
        check_cond("cmp_hs", 4'd11, 1'b1);
        check_cond("cmp_ge", 4'd13, 1'b1);
        check_cond("cmp_lo", 4'd10, 1'b0);

        // PSR priority
        offer(4'd0, 16'h0, 1'b0, 1'b1, 5'b10000);
        psr_we    = 1'b1;
        psr_wdata = 5'b00101;
        step();
        idle_inputs();
        check("prio_psr", 32'(psr), 32'h05);
        check_cond("prio_cs", 4'd2, 1'b1);
        check_cond("prio_fs", 4'd8, 1'b1);
        check_cond("prio_lt", 4'd12, 1'b1);

        // Condition table
        for (int i = 0; i < 25; i++) begin
            psr_we    = 1'b1;
            psr_wdata = vecs[i].p;
            step();
            psr_we = 1'b0;
            check($sformatf("tbl%0d_psr", i), 32'(psr), 32'(vecs[i].p));
            check_cond($sformatf("tbl%0d_cond%0d", i, vecs[i].c), vecs[i].c, vecs[i].exp);
        end

        // Reset mid-operation
        wb_ready = 1'b0;
        offer(4'd7, 16'h7777, 1'b1, 1'b1, 5'b10011);
        step();
        offer(4'd8, 16'h8888, 1'b1, 1'b0, 5'b0);
        step();
        idle_inputs();
        check("mid_full", 32'(in_ready), 32'h0);
        check("mid_psr_set", 32'(psr), 32'h13);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid", 32'(wb_valid), 32'h0);
        check("mid_rst_psr", 32'(psr), 32'h0);
        check("mid_rst_ready", 32'(in_ready), 32'h1);
        wb_ready = 1'b1;
        step();
        check("mid_no_stale", 32'(wb_valid), 32'h0);
        step();
        check("mid_no_stale2", 32'(wb_valid), 32'h0);

        // Randomized run against the queue model
        q.delete();
        mpsr = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic acc, pop;
            check("rnd_valid", 32'(wb_valid), 32'(q.size() != 0));
            check("rnd_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            check("rnd_busy", 32'(busy), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("rnd_addr", 32'(wb_addr), 32'(q[0].addr));
                check("rnd_data", 32'(wb_data), 32'(q[0].data));
            end
            check("rnd_psr", 32'(psr), 32'(mpsr));
            cond = 4'($urandom_range(0, 15));
            #1;
            check("rnd_cond", 32'(cond_true), 32'(ref_cond(mpsr, cond)));

            in_valid   = ($urandom_range(0, 1) == 1);
            in_data    = 16'($urandom);
            in_rdest   = 4'($urandom);
            in_flags   = 5'($urandom);
            in_wr_en   = ($urandom_range(0, 3) != 0);
            in_flag_we = ($urandom_range(0, 1) == 1);
            psr_we     = ($urandom_range(0, 7) == 0);
            psr_wdata  = 5'($urandom);
            wb_ready   = ($urandom_range(0, 1) == 1);

            acc = in_valid && (q.size() < DEPTH);
            pop = (q.size() != 0) && wb_ready;
            if (pop) void'(q.pop_front());
            if (acc && in_wr_en) q.push_back('{addr: in_rdest, data: in_data});
            if (psr_we) mpsr = psr_wdata;
            else if (acc && in_flag_we) mpsr = in_flags;
            step();
        end
        idle_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
